// File: rtl/sync_short_ctrl_if.sv
// Handshake bundle between the receiver front-end controller and its sync/receiver stages.
interface sync_short_ctrl_if;
  logic       Start;
  logic       In_Strobe;
  logic       Short_Det;
  logic       Long_Done;
  logic       Rx_Done;
  logic       Det_En;
  logic       Long_En;
  logic       Rx_En;
  logic       Pkt_Det;
  logic       Sync_Ok;
  logic       Timeout;
  logic [2:0] State;

  modport master (
    output Start, In_Strobe, Short_Det, Long_Done, Rx_Done,
    input  Det_En, Long_En, Rx_En, Pkt_Det, Sync_Ok, Timeout, State
  );

  modport slave (
    input  Start, In_Strobe, Short_Det, Long_Done, Rx_Done,
    output Det_En, Long_En, Rx_En, Pkt_Det, Sync_Ok, Timeout, State
  );
endinterface

// File: rtl/sync_short_ctrl.sv
// Sequences short-preamble detect, long-preamble fine sync and payload receive,
// with a strobe-counted long-preamble window and automatic re-arm.
module sync_short_ctrl #(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CLR_W      = 2,
  parameter int unsigned LONG_WIN   = 320,
  parameter int unsigned WIN_W      = 9
) (
  input  logic              CLK,
  input  logic              a_RST_n,
  sync_short_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SEARCH = 3'd2,
    LONG   = 3'd3,
    RX     = 3'd4
  } state_t;

  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(LONG_WIN - 1);

  state_t            state;
  logic [CLR_W-1:0]  clr_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic              det_en;
  logic              long_en;
  logic              rx_en;
  logic              pkt_det;
  logic              sync_ok;
  logic              timeout_q;

  // Enable pattern {det, long, rx} for the state being entered
  function automatic logic [2:0] en_of(input state_t s);
    case (s)
      SEARCH:  en_of = 3'b100;
      LONG:    en_of = 3'b010;
      RX:      en_of = 3'b001;
      default: en_of = 3'b000;
    endcase
  endfunction

  // Single-process FSM; enables follow the state being entered on the same edge
  always_ff @(posedge CLK or negedge a_RST_n) begin
    if (!a_RST_n) begin
      state                     <= IDLE;
      clr_cnt                   <= '0;
      win_cnt                   <= '0;
      {det_en, long_en, rx_en}  <= 3'b000;
      pkt_det                   <= 1'b0;
      sync_ok                   <= 1'b0;
      timeout_q                 <= 1'b0;
    end else begin
      pkt_det   <= 1'b0;
      sync_ok   <= 1'b0;
      timeout_q <= 1'b0;
      if (state != IDLE && !bus.Start) begin
        state                    <= IDLE;
        {det_en, long_en, rx_en} <= en_of(IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (bus.Start) begin
              state                    <= CLEAR;
              clr_cnt                  <= '0;
              {det_en, long_en, rx_en} <= en_of(CLEAR);
            end
          end
          CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
              state                    <= SEARCH;
              {det_en, long_en, rx_en} <= en_of(SEARCH);
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          SEARCH: begin
            if (bus.Short_Det) begin
              state                    <= LONG;
              win_cnt                  <= '0;
              pkt_det                  <= 1'b1;
              {det_en, long_en, rx_en} <= en_of(LONG);
            end
          end
          LONG: begin
            // Lock takes priority over a window expiring on the same strobe
            if (bus.Long_Done) begin
              state                    <= RX;
              sync_ok                  <= 1'b1;
              {det_en, long_en, rx_en} <= en_of(RX);
            end else if (bus.In_Strobe) begin
              if (win_cnt == WIN_LAST) begin
                state                    <= CLEAR;
                clr_cnt                  <= '0;
                timeout_q                <= 1'b1;
                {det_en, long_en, rx_en} <= en_of(CLEAR);
              end else begin
                win_cnt <= win_cnt + WIN_W'(1);
              end
            end
          end
          RX: begin
            if (bus.Rx_Done) begin
              state                    <= CLEAR;
              clr_cnt                  <= '0;
              {det_en, long_en, rx_en} <= en_of(CLEAR);
            end
          end
          default: begin
            state                    <= IDLE;
            {det_en, long_en, rx_en} <= en_of(IDLE);
          end
        endcase
      end
    end
  end

  assign bus.State   = 3'(state);
  assign bus.Det_En  = det_en;
  assign bus.Long_En = long_en;
  assign bus.Rx_En   = rx_en;
  assign bus.Pkt_Det = pkt_det;
  assign bus.Sync_Ok = sync_ok;
  assign bus.Timeout = timeout_q;

endmodule
